// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM.
// Holds the clear/run FSM encoding and the legal read-latency bounds.
package dp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dp_ram_out_pipe.sv
// Optional second read-data register stage, one instance per RAM port.
// The flush input zeroes the stage so stale data never leaks out of a clear.
module dp_ram_out_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_reg;

    always_ff @(posedge clk) begin
        if (flush) begin
            dout_reg <= '0;
        end else begin
            dout_reg <= din;
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/dp_ram_be.sv
// True dual-port, read-first RAM with per-byte write enables and a self-clear after reset.
// Define DP_RAM_BE_COLLISION_CHECK_EN to add the registered same-address write collision output.
module dp_ram_be
    import dp_ram_pkg::*;
#(
    parameter int RAM_WIDTH  = 64,
    parameter int RAM_DEPTH  = 512,
    parameter int RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ready,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         wea,
    input  logic [RAM_WIDTH/8-1:0]       bea,
    output logic [RAM_WIDTH-1:0]         douta,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         web,
    input  logic [RAM_WIDTH/8-1:0]       beb,
    output logic [RAM_WIDTH-1:0]         doutb
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
    ,
    output logic                         collision
`endif
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int NB = RAM_WIDTH / 8;

    ram_state_t      state_reg;
    logic [AW-1:0]   clr_addr_reg;
    logic            ready_reg;

    logic            clear_we;
    logic            run_we;
    logic            flush;
    logic [RAM_WIDTH-1:0] rd_a;
    logic [RAM_WIDTH-1:0] rd_b;

    // RAM_DEPTH is a power of two, so the last clear address is all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
            ready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (&clr_addr_reg) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    state_reg <= RUN;
                end
                default: begin
                    state_reg <= CLEAR;
                end
            endcase
        end
    end

    assign clear_we = !reset && (state_reg == CLEAR);
    assign run_we   = !reset && (state_reg == RUN);
    assign flush    = reset || (state_reg == CLEAR);
    assign ready    = ready_reg;

    // One byte-wide memory per lane; port A is written last so it wins on shared bytes.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] lane_mem [RAM_DEPTH];
        logic [7:0] rda_reg;
        logic [7:0] rdb_reg;

        always_ff @(posedge clk) begin
            if (clear_we) begin
                lane_mem[clr_addr_reg] <= '0;
            end else if (run_we) begin
                if (web && beb[gi]) begin
                    lane_mem[addrb] <= dinb[gi*8 +: 8];
                end
                if (wea && bea[gi]) begin
                    lane_mem[addra] <= dina[gi*8 +: 8];
                end
            end

            if (flush) begin
                rda_reg <= '0;
                rdb_reg <= '0;
            end else begin
                rda_reg <= lane_mem[addra];
                rdb_reg <= lane_mem[addrb];
            end
        end

        assign rd_a[gi*8 +: 8] = rda_reg;
        assign rd_b[gi*8 +: 8] = rdb_reg;
    end

    if (RD_LATENCY >= RD_LAT_MAX) begin : g_lat2
        dp_ram_out_pipe #(
            .WIDTH (RAM_WIDTH)
        ) u_pipe_a (
            .clk   (clk),
            .flush (flush),
            .din   (rd_a),
            .dout  (douta)
        );

        dp_ram_out_pipe #(
            .WIDTH (RAM_WIDTH)
        ) u_pipe_b (
            .clk   (clk),
            .flush (flush),
            .din   (rd_b),
            .dout  (doutb)
        );
    end else begin : g_lat1
        assign douta = rd_a;
        assign doutb = rd_b;
    end

`ifdef DP_RAM_BE_COLLISION_CHECK_EN
    logic collision_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= run_we && wea && web && (addra == addrb) && (|(bea & beb));
        end
    end

    assign collision = collision_reg;
`endif

endmodule

// File: tb/tb_dp_ram_be.sv
// Scoreboard bench for dp_ram_be: a latency-1 and a latency-2 instance share one stimulus stream.
// Expected read data is queued when an address is driven and compared when each instance delivers it.
module tb_dp_ram_be;

    localparam int W  = 64;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [W-1:0]  dina = '0, dinb = '0;
    logic          wea = 1'b0, web = 1'b0;
    logic [NB-1:0] bea = '0, beb = '0;

    logic          ready1, ready2;
    logic [W-1:0]  douta1, doutb1, douta2, doutb2;
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
    logic          collision1, collision2;
`endif

    always #5 clk = ~clk;

    dp_ram_be #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(1)) u_dut1 (
        .clk   (clk),   .reset (reset), .ready (ready1),
        .addra (addra), .dina  (dina),  .wea   (wea), .bea (bea), .douta (douta1),
        .addrb (addrb), .dinb  (dinb),  .web   (web), .beb (beb), .doutb (doutb1)
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
        , .collision (collision1)
`endif
    );

    dp_ram_be #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(2)) u_dut2 (
        .clk   (clk),   .reset (reset), .ready (ready2),
        .addra (addra), .dina  (dina),  .wea   (wea), .bea (bea), .douta (douta2),
        .addrb (addrb), .dinb  (dinb),  .web   (web), .beb (beb), .doutb (doutb2)
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
        , .collision (collision2)
`endif
    );

    typedef struct {
        int          due;
        string       tag;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    logic [W-1:0] m [D];
    bit           model_ready = 1'b0;
    int           clr_cnt = 0;
    int           cyc = 0;
    int           n_total = 0;
    int           n_bad = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // One clock: queue expectations from pre-write model state, update model, clock, retire due entries.
    task automatic step(input bit chk, input string tag);
        exp_t e;
        e.tag = tag;
        e.a   = model_ready ? m[addra] : '0;
        e.b   = model_ready ? m[addrb] : '0;
        if (chk) begin
            e.due = cyc + 1;
            q1.push_back(e);
            e.due = cyc + 2;
            q2.push_back(e);
        end
        if (model_ready && !reset) begin
            for (int i = 0; i < NB; i++) begin
                if (web && beb[i]) m[addrb][i*8 +: 8] = dinb[i*8 +: 8];
            end
            for (int i = 0; i < NB; i++) begin
                if (wea && bea[i]) m[addra][i*8 +: 8] = dina[i*8 +: 8];
            end
        end
        if (reset) begin
            model_ready = 1'b0;
            clr_cnt = 0;
            for (int i = 0; i < D; i++) m[i] = '0;
        end else if (!model_ready) begin
            clr_cnt++;
            if (clr_cnt == D) model_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            check_val({e.tag, "_a_lat1"}, douta1, e.a);
            check_val({e.tag, "_b_lat1"}, doutb1, e.b);
        end
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            e = q2.pop_front();
            check_val({e.tag, "_a_lat2"}, douta2, e.a);
            check_val({e.tag, "_b_lat2"}, doutb2, e.b);
        end
    endtask

    task automatic idle();
        wea = 1'b0; web = 1'b0; bea = '0; beb = '0;
    endtask

    task automatic drain();
        idle();
        repeat (3) step(1'b0, "");
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready1 && n < 40) begin
            step(1'b0, "");
            n++;
        end
        check_val({tag, "_clear_cycles"}, 64'(n), 64'(D));
        check_val({tag, "_ready_lat2"}, 64'(ready2), 64'(1));
    endtask

    initial begin
        // Reset state
        repeat (3) step(1'b0, "");
        check_val("rst_ready1", 64'(ready1), 64'(0));
        check_val("rst_ready2", 64'(ready2), 64'(0));
        check_val("rst_douta1", douta1, '0);
        check_val("rst_doutb2", doutb2, '0);
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
        check_val("rst_collision", 64'(collision1), 64'(0));
`endif

        // Clear length after first release, then every word reads zero
        reset = 1'b0;
        wait_ready("clr1");
        for (int i = 0; i < D; i++) begin
            addra = AW'(i);
            addrb = AW'(D - 1 - i);
            step(1'b1, "zero");
        end
        drain();

        // Byte-enable merge on addr 3
        addra = 4'd3; dina = 64'h1122334455667788; wea = 1'b1; bea = 8'hFF;
        step(1'b0, "");
        dina = 64'h00000000000000AA; bea = 8'h01;
        step(1'b0, "");
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
        check_val("no_collision_a_only", 64'(collision1), 64'(0));
`endif
        idle();
        step(1'b1, "be_merge");
        check_val("be_merge_word", m[3], 64'h11223344556677AA);
        drain();

        // Same-address dual write: A wins shared bytes
        addra = 4'd5; dina = '1; wea = 1'b1; bea = 8'h0F;
        addrb = 4'd5; dinb = '0; web = 1'b1; beb = 8'hFF;
        step(1'b0, "");
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
        check_val("collision_pulse", 64'(collision1), 64'(1));
`endif
        idle();
        step(1'b1, "dual_wr");
`ifdef DP_RAM_BE_COLLISION_CHECK_EN
        check_val("collision_clear", 64'(collision1), 64'(0));
`endif
        check_val("dual_wr_word", m[5], 64'h00000000FFFFFFFF);
        drain();

        // Read-first: B reads addr 7 while A overwrites it
        addrb = 4'd7; dinb = 64'h5; web = 1'b1; beb = 8'hFF;
        step(1'b0, "");
        idle();
        addra = 4'd7; dina = 64'h9; wea = 1'b1; bea = 8'hFF;
        step(1'b1, "rd_first");
        idle();
        step(1'b1, "after_wr");
        drain();

        // Mixed random traffic
        for (int i = 0; i < 40; i++) begin
            addra = AW'($urandom_range(D - 1));
            addrb = AW'($urandom_range(D - 1));
            dina  = {$urandom, $urandom};
            dinb  = {$urandom, $urandom};
            wea   = 1'($urandom);
            web   = 1'($urandom);
            bea   = NB'($urandom);
            beb   = NB'($urandom);
            step(1'b1, "rand");
        end
        drain();

        // Reset in RUN, abort the clear at cycle 8, writes during clear must not stick
        reset = 1'b1;
        step(1'b0, "");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addra = AW'(i); dina = '1; wea = 1'b1; bea = 8'hFF;
            step(1'b0, "");
            check_val("partial_clr_ready", 64'(ready1), 64'(0));
        end
        reset = 1'b1;
        step(1'b0, "");
        reset = 1'b0;
        addra = 4'd9; dina = '1; wea = 1'b1; bea = 8'hFF;
        wait_ready("clr2");
        idle();
        for (int i = 0; i < D; i++) begin
            addra = AW'(i);
            addrb = AW'(i);
            step(1'b1, "reclr");
        end
        drain();

        // Back-to-back reads 0,1,2 after distinct writes
        for (int i = 0; i < 3; i++) begin
            addra = AW'(i); dina = 64'hA0 + 64'(i); wea = 1'b1; bea = 8'hFF;
            step(1'b0, "");
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            addra = AW'(i);
            addrb = AW'(2 - i);
            step(1'b1, "b2b");
        end
        drain();

        check_val("queues_empty", 64'(q1.size() + q2.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dp_ram_be.md
DP_RAM_BE -- requirements
Module: dp_ram_be

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 64: data width in bits; multiple of 8.
REQ-002 SHALL have parameter RAM_DEPTH, default 512: word count; power of two, at least 2.
REQ-003 SHALL have parameter RD_LATENCY, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 SHALL derive localparams AW = $clog2(RAM_DEPTH) and NB = RAM_WIDTH/8.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port ready, output, 1: high when the memory is cleared and accepting accesses.
REQ-008 SHALL have port addra, input, AW: port A word address.
REQ-009 SHALL have port dina, input, RAM_WIDTH: port A write data.
REQ-010 SHALL have port wea, input, 1: port A write enable.
REQ-011 SHALL have port bea, input, NB: port A byte enables; bit i gates dina[8i+7:8i].
REQ-012 SHALL have port douta, output, RAM_WIDTH: port A read data.
REQ-013 SHALL have ports addrb, dinb, web, beb and doutb, mirroring port A.
REQ-014 SHALL have port collision, output, 1, present only under DP_RAM_BE_COLLISION_CHECK_EN.

Function
REQ-015 SHALL read on every cycle at both ports; douta/doutb carry mem[addr] RD_LATENCY cycles after the address is sampled.
REQ-016 SHALL be read-first: a read of the address written in the same cycle, from either port, returns the pre-write data.
REQ-017 SHALL write only the bytes with set byte-enable bits when we=1; we=1 with be=0 leaves the memory unchanged.
REQ-018 SHALL, when both ports write the same address in one cycle, take port A's value for bytes enabled on both ports and each port's own value for bytes enabled on only one port.
REQ-019 SHALL use FSM states CLEAR and RUN, entering CLEAR on reset.
REQ-020 SHALL, in CLEAR, write zero to address clr_addr each cycle and increment clr_addr from 0 to RAM_DEPTH-1.
REQ-021 SHALL, in CLEAR, ignore wea/web and force douta/doutb to 0.
REQ-022 SHALL move from CLEAR to RUN in the cycle after the write to RAM_DEPTH-1, and ready SHALL rise in that cycle; the clear lasts exactly RAM_DEPTH cycles after reset deasserts.
REQ-023 SHALL, when RD_LATENCY=2, add a second register stage per output; the output pipeline SHALL flush to 0 while in CLEAR.

Reset
REQ-024 SHALL, while reset=1, drive ready=0, douta=0, doutb=0 and collision=0, set clr_addr=0 and set state=CLEAR.
REQ-025 SHALL, when reset is asserted mid-clear, restart the clear from address 0.
REQ-026 SHALL, when reset is asserted in RUN, re-clear the entire memory.

Configuration
REQ-027 SHALL, with DP_RAM_BE_COLLISION_CHECK_EN defined, register a collision pulse one cycle after a cycle in RUN where wea and web are both 1, addra==addrb and (bea & beb) is nonzero.
REQ-028 SHALL, without DP_RAM_BE_COLLISION_CHECK_EN, have no collision port and no collision logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state enum (CLEAR, RUN) and the legal RD_LATENCY bounds in package dp_ram_pkg.
REQ-030 SHALL implement the optional second output stage as sub-module dp_ram_out_pipe, instantiated once per port.

Verification
REQ-031 SHALL cover: RAM_DEPTH=16, reset released -> ready low for exactly 16 cycles, then high; reading every address returns 0.
REQ-032 SHALL cover: write A addr 3 = 0x1122334455667788 with bea=0xFF, then bea=0x01 with dina=0xAA -> read returns 0x11223344556677AA after RD_LATENCY cycles.
REQ-033 SHALL cover: same cycle, A writes addr 5 = all-ones with bea=0x0F and B writes addr 5 = 0 with beb=0xFF -> word = 0x00000000FFFFFFFF, and collision pulses one cycle later when the macro is defined.
REQ-034 SHALL cover: B reads addr 7 (holding 0x5) while A writes 0x9 to addr 7 -> doutb=0x5, and the next read returns 0x9.
REQ-035 SHALL cover: reset pulsed at clear cycle 8 with RAM_DEPTH=16 -> ready rises 16 cycles after the second release; wea pulses issued during the clear leave no data.
REQ-036 SHALL cover: RD_LATENCY=2, back-to-back reads of addrs 0,1,2 -> data appears 2 cycles after each address, one word per cycle.
